// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared definitions for the IF->ID pipeline register slice: default payload
//   widths, the payload struct and the occupancy/state encoding.
//   The state encoding doubles as the occupancy count (EMPTY=0, ONE=1, TWO=2).
package pipe_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned PC_W_DEF   = 32;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] inst;
      logic [PC_W_DEF-1:0]   pc;
      logic                  stop;
   } pipe_payload_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_state_e;

endpackage

// File: rtl/pipe_payload_reg.sv
// pipe_payload_reg
//   Enable-loaded payload register with asynchronous active-low reset to zero.
//   Ports:
//     clk    - rising-edge clock
//     rstn   - asynchronous active-low reset (clears the held value)
//     load_i - capture d_i on the next rising edge
//     d_i    - value to capture
//     q_o    - held value
module pipe_payload_reg
   import pipe_pkg::*;
#(
   parameter int unsigned W = DATA_W_DEF + PC_W_DEF + 1
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] data_d, data_q;

   always_comb begin
      data_d = load_i ? d_i : data_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
//   Valid/ready pipeline register between IF and ID.
//   Build option: define PIPE_SKID_EN for the two-entry skid version, in which
//   in_ready is a flop (no combinational path from out_ready). Without it the
//   block is a single register with in_ready = !out_valid || out_ready.
//   Ports:
//     clk, rstn                  - clock, asynchronous active-low reset
//     flush_in                   - synchronous flush, drops all held entries
//     in_valid/in_ready          - upstream handshake
//     in_inst/in_pc/in_stop      - upstream payload
//     out_valid/out_ready        - downstream handshake
//     out_inst/out_pc/out_stop   - payload, always sourced from the main entry
//     occupancy                  - number of held entries
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned PC_W   = PC_W_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush_in,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_inst,
   input  logic [PC_W-1:0]   in_pc,
   input  logic              in_stop,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_inst,
   output logic [PC_W-1:0]   out_pc,
   output logic              out_stop,
   output logic [1:0]        occupancy
);

   localparam int unsigned PAY_W = DATA_W + PC_W + 1;

   localparam logic [1:0] ST_EMPTY = EMPTY;
   localparam logic [1:0] ST_ONE   = ONE;
   localparam logic [1:0] ST_TWO   = TWO;

   logic [1:0]       state_d, state_q;
   logic             accept, drain;
   logic             main_load;
   logic [PAY_W-1:0] in_pay, main_d, main_q;

   assign in_pay    = {in_inst, in_pc, in_stop};
   assign out_valid = (state_q != ST_EMPTY);
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;
   assign occupancy = state_q;
   assign {out_inst, out_pc, out_stop} = main_q;

`ifdef PIPE_SKID_EN

   logic             skid_load;
   logic [PAY_W-1:0] skid_q;
   logic             in_ready_d, in_ready_q;

   // Flush only changes the state; payload registers keep their old contents.
   always_comb begin
      state_d   = state_q;
      main_load = 1'b0;
      main_d    = in_pay;
      skid_load = 1'b0;
      if (flush_in) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  main_load = 1'b1;
                  state_d   = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && drain) begin
                  main_load = 1'b1;
               end else if (accept) begin
                  skid_load = 1'b1;
                  state_d   = ST_TWO;
               end else if (drain) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               // in_ready is low here, so only a drain can happen.
               if (drain) begin
                  main_load = 1'b1;
                  main_d    = skid_q;
                  state_d   = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      // Registered ready tracks the next state so it is valid the cycle it matters.
      in_ready_d = (state_d != ST_TWO);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         in_ready_q <= 1'b1;
      end else begin
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready = in_ready_q;

   pipe_payload_reg #(
      .W (PAY_W)
   ) u_skid_reg (
      .clk    (clk),
      .rstn   (rstn),
      .load_i (skid_load),
      .d_i    (in_pay),
      .q_o    (skid_q)
   );

`else

   assign in_ready = !out_valid || out_ready;

   always_comb begin
      state_d   = state_q;
      main_load = 1'b0;
      main_d    = in_pay;
      if (flush_in) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  main_load = 1'b1;
                  state_d   = ST_ONE;
               end
            end
            ST_ONE: begin
               // An accept while full implies out_ready, i.e. a simultaneous drain.
               if (accept) begin
                  main_load = 1'b1;
               end else if (drain) begin
                  state_d = ST_EMPTY;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   pipe_payload_reg #(
      .W (PAY_W)
   ) u_main_reg (
      .clk    (clk),
      .rstn   (rstn),
      .load_i (main_load),
      .d_i    (main_d),
      .q_o    (main_q)
   );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg
//   Directed bench for pipe_skid_reg with a payload scoreboard. Works with and
//   without PIPE_SKID_EN; skid-only steps are selected by the same macro.
module tb_pipe_skid_reg;
   import pipe_pkg::*;

   logic        clk;
   logic        rstn;
   logic        flush_in;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic        in_stop;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_stop;
   logic [1:0]  occupancy;

   int checks = 0;
   int errors = 0;

   pipe_payload_t sb[$];

   pipe_skid_reg #(
      .DATA_W (32),
      .PC_W   (32)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .flush_in  (flush_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_inst   (in_inst),
      .in_pc     (in_pc),
      .in_stop   (in_stop),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .out_pc    (out_pc),
      .out_stop  (out_stop),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive, compare against the model, update the model, advance.
   // Called just after a falling edge; returns just after the next falling edge.
   task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic stp, input logic ordy, input logic fl);
      pipe_payload_t exp_p;
      pipe_payload_t new_p;
      logic          exp_rdy;
      in_valid  = v;
      in_inst   = inst;
      in_pc     = pc;
      in_stop   = stp;
      out_ready = ordy;
      flush_in  = fl;
      #1;
`ifdef PIPE_SKID_EN
      exp_rdy = (sb.size() != 2);
`else
      exp_rdy = (sb.size() == 0) || ordy;
`endif
      chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      chk("occupancy", 64'(occupancy), 64'(sb.size()));
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (sb.size() != 0) begin
         exp_p = sb[0];
         chk("out_inst", 64'(out_inst), 64'(exp_p.inst));
         chk("out_pc", 64'(out_pc), 64'(exp_p.pc));
         chk("out_stop", 64'(out_stop), 64'(exp_p.stop));
      end
      if (fl) begin
         sb.delete();
      end else begin
         if (sb.size() != 0 && ordy) void'(sb.pop_front());
         if (v && exp_rdy) begin
            new_p.inst = inst;
            new_p.pc   = pc;
            new_p.stop = stp;
            sb.push_back(new_p);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rstn      = 1'b0;
      flush_in  = 1'b0;
      in_valid  = 1'b0;
      in_inst   = '0;
      in_pc     = '0;
      in_stop   = 1'b0;
      out_ready = 1'b0;

      // Reset values, before and after a clock edge under reset.
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_inst", 64'(out_inst), 64'd0);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      chk("rst_out_pc", 64'(out_pc), 64'd0);
      chk("rst_out_stop", 64'(out_stop), 64'd0);
      chk("rst_occupancy2", 64'(occupancy), 64'd0);
      rstn = 1'b1;

      // Streaming, one transfer per cycle.
      cycle(1'b1, 32'h0000_0013, 32'h0000_1000, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 32'h0010_0093, 32'h0000_1004, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 32'h0020_0113, 32'h0000_1008, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("stream_sb_empty", 64'(sb.size()), 64'd0);

      // Backpressure.
`ifdef PIPE_SKID_EN
      cycle(1'b1, 32'hAAAA_0001, 32'h0000_2000, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'hBBBB_0002, 32'h0000_2004, 1'b0, 1'b0, 1'b0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("bp_occupancy2", 64'(occupancy), 64'd2);
      chk("bp_in_ready0", 64'(in_ready), 64'd0);
      chk("bp_head_a", 64'(out_inst), 64'hAAAA_0001);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      out_ready = 1'b1;
      #1;
      chk("bp_in_ready1", 64'(in_ready), 64'd1);
      chk("bp_head_b", 64'(out_inst), 64'hBBBB_0002);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
`else
      cycle(1'b1, 32'hAAAA_0001, 32'h0000_2000, 1'b0, 1'b0, 1'b0);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      #1;
      chk("bp_occupancy1", 64'(occupancy), 64'd1);
      chk("bp_in_ready0", 64'(in_ready), 64'd0);
      cycle(1'b1, 32'hBBBB_0002, 32'h0000_2004, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'hBBBB_0002, 32'h0000_2004, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
`endif
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("bp_sb_empty", 64'(sb.size()), 64'd0);

      // Flush while full, with a new payload offered in the same cycle.
      cycle(1'b1, 32'hF100_0001, 32'h0000_3000, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_SKID_EN
      cycle(1'b1, 32'hF200_0002, 32'h0000_3004, 1'b0, 1'b0, 1'b0);
`endif
      cycle(1'b1, 32'hCCCC_0003, 32'h0000_3008, 1'b0, 1'b0, 1'b1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush_in  = 1'b0;
      #1;
      chk("fl_out_valid", 64'(out_valid), 64'd0);
      chk("fl_occupancy", 64'(occupancy), 64'd0);
      cycle(1'b1, 32'hDDDD_0004, 32'h0000_300C, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset between clock edges while full.
      cycle(1'b1, 32'h6161_0001, 32'h0000_4000, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_SKID_EN
      cycle(1'b1, 32'h6262_0002, 32'h0000_4004, 1'b0, 1'b0, 1'b0);
`endif
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      rstn = 1'b0;
      #1;
      chk("ar_out_valid", 64'(out_valid), 64'd0);
      chk("ar_occupancy", 64'(occupancy), 64'd0);
      chk("ar_in_ready", 64'(in_ready), 64'd1);
      chk("ar_out_inst", 64'(out_inst), 64'd0);
      sb.delete();
      #1;
      rstn = 1'b1;
      @(negedge clk);
      cycle(1'b1, 32'hEEEE_0005, 32'h0000_5000, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("end_sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the instruction payload.
REQ-002 Parameter PC_W, default 32, width of the program-counter payload.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rstn  input  1  reset, asynchronous, active-low.
REQ-005 Port flush_in  input  1  synchronous pipeline flush (branch mispredict / exception).
REQ-006 Port in_valid  input  1  upstream (IF) payload valid.
REQ-007 Port in_ready  output  1  stage can accept the upstream payload this cycle.
REQ-008 Port in_inst  input  DATA_W  instruction from IF.
REQ-009 Port in_pc  input  PC_W  PC of in_inst.
REQ-010 Port in_stop  input  1  end-of-program marker travelling with the instruction.
REQ-011 Port out_valid  output  1  downstream (ID) payload valid.
REQ-012 Port out_ready  input  1  downstream accepts the payload this cycle.
REQ-013 Port out_inst / out_pc / out_stop  output  DATA_W / PC_W / 1  payload presented to ID.
REQ-014 Port occupancy  output  2  number of held entries (0..2), for debug and performance counters.

Function
REQ-015 The block SHALL accept a payload on a cycle with in_valid && in_ready, and SHALL deliver a payload on a cycle with out_valid && out_ready.
REQ-016 Accept-to-out_valid latency SHALL be exactly 1 cycle when the stage is empty.
REQ-017 Payloads SHALL leave in acceptance order; none SHALL be duplicated or dropped except by flush.
REQ-018 Internal states SHALL be EMPTY (occupancy 0), ONE (1) and TWO (2, skid entry occupied).
REQ-019 EMPTY: accept -> ONE (main register loads the input); otherwise stay.
REQ-020 ONE: accept && drain -> ONE (main register loads the input); accept only -> TWO (skid register loads the input); drain only -> EMPTY; neither -> stay.
REQ-021 TWO: in_ready=0; drain -> ONE (main register loads the skid register); otherwise stay.
REQ-022 out_valid SHALL equal (state != EMPTY); out_* SHALL always come from the main register.
REQ-023 The payload SHALL remain stable while out_valid && !out_ready.
REQ-024 flush_in SHALL have priority over every other event: next state EMPTY, any input offered in the same cycle discarded, and the held payload values left unchanged (only valid is cleared).
REQ-025 In skid mode, in_ready SHALL be a registered signal, equal to (state != TWO), with no combinational path from out_ready.
REQ-026 Sustained in_valid=1 && out_ready=1 SHALL give one transfer per cycle.

Reset
REQ-027 While rstn=0: state EMPTY, out_valid=0, occupancy=0, out_inst=0, out_pc=0, out_stop=0, skid payload=0.
REQ-028 In skid mode, in_ready SHALL be 1 during reset.
REQ-029 Reset asserted mid-operation SHALL discard all held entries immediately.

Configuration
REQ-030 Macro PIPE_SKID_EN defined: the two-entry skid behaviour of REQ-018 to REQ-025 applies.
REQ-031 Macro PIPE_SKID_EN undefined:
- the skid register is not built and the state never reaches TWO;
- occupancy is limited to 0..1;
- in_ready = !out_valid || out_ready (combinational);
- all other requirements are unchanged.

Structure
REQ-032 A shared package pipe_pkg SHALL hold the default widths, the pipe_payload_t struct (inst, pc, stop) and the state enum (EMPTY/ONE/TWO).
REQ-033 One sub-module, pipe_payload_reg (enable-loaded, async-reset payload register), SHALL be instantiated for the main entry and for the skid entry.

Verification
REQ-034 Reset check: with rstn=0, out_valid=0, out_inst=0, occupancy=0, in_ready=1 in both configurations.
REQ-035 Streaming: in_valid=1, out_ready=1, inst=0x00000013, 0x00100093, 0x00200113 on consecutive cycles -> the same three values appear on out_inst in order, one cycle later each, with no bubbles.
REQ-036 Backpressure (PIPE_SKID_EN defined):
- out_ready=0 and two payloads A=0xAAAA0001, B=0xBBBB0002 accepted -> occupancy=2 and in_ready=0 in the next cycle;
- out_ready=1 -> A, then B delivered, and in_ready returns to 1 after the cycle in which A is delivered.
REQ-037 Flush: occupancy=2 and flush_in=1 together with in_valid=1 -> next cycle out_valid=0, occupancy=0; the flushed and offered payloads are never delivered.
REQ-038 Async reset mid-stream: rstn low between clock edges at occupancy=2 -> out_valid drops with no clock edge; after release the next accepted payload is delivered first.
